mips_multi_controller: RTL and testbench

- Main control unit of the multicycle MIPS core; sequences the shared datapath (PC, unified memory, IR, register file, single ALU) one instruction at a time.
- Moore FSM plus combinational ALU decoder, driving every datapath mux select and write enable.
- Produces the 3-bit ALU operation code consumed by the ALU: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Instruction sources are the IR `op`/`funct` fields; the branch condition is the ALU `zero` flag.

---
 rtl/mips_multi_controller.sv | 201 ++++++++++++++++++++
 tb/tb_mips_multi_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_controller.sv
// ---------------------------------------------------------------------------
// mips_multi_controller
//
// Main control unit of the multicycle MIPS core. A Moore FSM steps the shared
// datapath (PC, unified memory, IR, register file, single ALU) through one
// instruction at a time. A combinational ALU decoder turns the R-type funct
// field into the 3-bit ALU operation code:
//   010 add, 110 sub, 000 and, 001 or, 111 slt.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (state -> FETCH)
//   op, funct    IR[31:26] and IR[5:0]; op must stay stable for the whole
//                instruction because the controller does not latch it
//   zero         ALU zero flag (branch condition)
//   pc_en        PC load enable = pc_write | (branch & zero)
//   i_or_d       memory address select (0 PC, 1 ALUOut)
//   mem_write    memory write enable
//   ir_write     IR load enable
//   reg_dst      write register select (0 rt, 1 rd)
//   mem_to_reg   write-back data select (0 ALUOut, 1 MDR)
//   reg_write    register file write enable
//   alu_src_a    ALU A select (0 PC, 1 reg A)
//   alu_src_b    ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pc_src       next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   alu_control  ALU operation code
//   illegal_op   one-cycle pulse on unsupported op (DECODE) or funct (EXECUTE)
//   state        current FSM state (debug)
// ---------------------------------------------------------------------------
module mips_multi_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_reg;
    logic [3:0] state_next;

    // Ungated decode; the enables below are masked with reset so nothing can
    // write while reset is held, whatever the state register is doing.
    logic pc_write_raw;
    logic branch_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic illegal_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        i_or_d        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_control   = ALU_ADD;

        case (state_reg)
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next  = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                i_or_d     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                i_or_d        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                state_next = S_ALUWB;
                case (funct)
                    6'b100000: alu_control = ALU_ADD;
                    6'b100010: alu_control = ALU_SUB;
                    6'b100100: alu_control = ALU_AND;
                    6'b100101: alu_control = ALU_OR;
                    6'b101010: alu_control = ALU_SLT;
                    default: begin
                        // Unknown funct still completes as an add.
                        alu_control = ALU_ADD;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch_raw  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: begin
                // FETCH, and the unused encodings 12-15 which behave as FETCH.
                alu_src_b    = 2'b01;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                state_next   = S_DECODE;
            end
        endcase
    end

    assign pc_en      = (pc_write_raw | (branch_raw & zero)) & ~reset;
    assign mem_write  = mem_write_raw & ~reset;
    assign ir_write   = ir_write_raw  & ~reset;
    assign reg_write  = reg_write_raw & ~reset;
    assign illegal_op = illegal_raw   & ~reset;
    assign state      = state_reg;

endmodule

// File: tb/tb_mips_multi_controller.sv
module tb_mips_multi_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    mips_multi_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_control(alu_control), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Per-state control table written out from the state list.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctl_t;

    ctl_t tbl [0:11];

    function automatic ctl_t mk(input logic pw, br, iod, mw, irw, rd, m2r, rw, sa,
                                input logic [1:0] sb, ps, input logic [2:0] ao);
        ctl_t c;
        c = '{pw, br, iod, mw, irw, rd, m2r, rw, sa, sb, ps, ao};
        return c;
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] r;
        r = 3'b010;
        if (f == 6'b100010) r = 3'b110;
        if (f == 6'b100100) r = 3'b000;
        if (f == 6'b100101) r = 3'b001;
        if (f == 6'b101010) r = 3'b111;
        return r;
    endfunction

    // Instruction-level model: the state walk for each opcode.
    function automatic void state_walk(input logic [5:0] o, output int q[$]);
        q = '{0, 1};
        case (o)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000100: q = '{0, 1, 8};
            6'b000010: q = '{0, 1, 11};
            default:   q = '{0, 1};
        endcase
    endfunction

    function automatic logic [15:0] expect_ctl(input int st, input logic [5:0] o,
                                               input logic [5:0] f, input logic z);
        ctl_t c;
        logic [2:0] ao;
        logic ill;
        c   = tbl[st];
        ao  = c.alu_op;
        ill = 1'b0;
        if (st == 6) begin
            ao  = funct_alu(f);
            ill = !funct_ok(f);
        end
        if (st == 1) ill = !(o inside {6'b100011, 6'b101011, 6'b000000,
                                       6'b001000, 6'b000100, 6'b000010});
        return {c.pc_write | (c.branch & z), c.i_or_d, c.mem_write, c.ir_write,
                c.reg_dst, c.mem_to_reg, c.reg_write, c.alu_src_a,
                c.alu_src_b, c.pc_src, ao, ill};
    endfunction

    function automatic logic [15:0] obs_ctl();
        return {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};
    endfunction

    // Called just after a rising edge with the DUT in FETCH. zmode<0: random zero.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        int q[$];
        state_walk(o, q);
        op    = o;
        funct = f;
        foreach (q[i]) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            check($sformatf("state op=%b step%0d", o, i), 32'(state), 32'(q[i]));
            check($sformatf("ctl op=%b f=%b s%0d z=%0d", o, f, q[i], zero),
                  32'(obs_ctl()), 32'(expect_ctl(q[i], o, f, zero)));
            @(posedge clk);
            #1;
        end
        $display("instr op=%b funct=%b cycles=%0d", o, f, q.size());
    endtask

    logic [5:0] ops [0:5];
    logic [5:0] functs [0:4];

    initial begin
        //                pw br iod mw irw rd m2r rw sa  sb     ps     alu
        tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
        tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010);
        tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010);
        tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);
        ops    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset enables", 32'({pc_en, ir_write, mem_write, reg_write, illegal_op}), 32'd0);
        check("reset alu_src_b", 32'(alu_src_b), 32'(2'b01));
        reset = 1'b0;
        #1;

        // Directed cases from the plan.
        run_instr(6'b100011, 6'b000000, -1);
        run_instr(6'b000000, 6'b101010, -1);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b000010, 6'b000000, -1);
        run_instr(6'b101011, 6'b000000, -1);
        run_instr(6'b111111, 6'b000000, -1);
        run_instr(6'b000000, 6'b000000, -1);
        run_instr(6'b001000, 6'b000000, -1);

        // Randomized mix of legal and arbitrary encodings.
        for (int n = 0; n < 150; n++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            run_instr(o, f, -1);
        end

        // Reset pulse in the middle of MEMRD.
        op   = 6'b100011;
        zero = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre-reset memrd", 32'(state), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset enables", 32'({pc_en, ir_write, mem_write, reg_write, illegal_op}), 32'd0);
        @(posedge clk);
        #1;
        check("held reset state", 32'(state), 32'd0);
        check("held reset enables", 32'({pc_en, ir_write, mem_write, reg_write, illegal_op}), 32'd0);
        reset = 1'b0;
        #1;
        check("release ir_write/pc_en", 32'({ir_write, pc_en}), 32'(2'b11));
        $display("reset mid-MEMRD done");
        run_instr(6'b100011, 6'b000000, -1);
        run_instr(6'b000000, 6'b100010, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
